// File: rtl/mat_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mat_mem_pkg
// Brief    : Shared types and constants for the matrix-memory read responder.
// Revision : 1.0 - initial release
// ============================================================================
package mat_mem_pkg;

  localparam int AW_DEF       = 10;
  localparam int DW_DEF       = 256;
  localparam int DEPTH_DEF    = 1024;
  localparam int SRAM_LAT_DEF = 1;

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_DRAIN = 2'd1,
    S_LOAD  = 2'd2
  } state_e;

  // Per-read tag travelling alongside the SRAM access
  typedef struct packed {
    logic vld;
    logic oor;
  } tag_t;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_fb(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mat_mem_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mat_mem_tag_pipe
// Brief    : Shift register of read tags covering SRAM latency plus the
//            output register; reports when no read is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module mat_mem_tag_pipe
  import mat_mem_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  tag_t tag_i,
  output tag_t tap_o,       // stage feeding the data output register
  output logic last_vld_o,  // final stage: drives the data-valid pulse
  output logic empty_o
);

  tag_t [STAGES-1:0] pipe_q;

  // Advance every tag one stage per clock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[STAGES-2:0], tag_i};
    end
  end

  // Pipeline is empty when no stage carries a valid read
  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      if (pipe_q[i].vld) empty_o = 1'b0;
    end
  end

  assign tap_o      = pipe_q[STAGES-2];
  assign last_vld_o = pipe_q[STAGES-1].vld;

endmodule
`default_nettype wire

// File: rtl/mat_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : mat_mem_resp
// Brief    : Matrix-memory read responder. Serves solver row reads from an
//            external single-port SRAM and hands the SRAM to a loader on
//            request after draining in-flight reads.
//            Optional macro MAT_MEM_STALL_INJ_EN: LFSR-driven rrdy stalls.
// Revision : 1.0 - initial release
// ============================================================================
module mat_mem_resp
  import mat_mem_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int SRAM_LAT = SRAM_LAT_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_mem_rreq,
  input  logic [AW-1:0] i_mem_addr,
  output logic          o_mem_rrdy,
  output logic [DW-1:0] o_mem_dout,
  output logic          o_mem_dout_vld,
  input  logic          i_ld_mode,
  input  logic          i_ld_wreq,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [DW-1:0] i_ld_data,
  output logic          o_ld_wrdy,
  output logic          o_ld_busy,
  output logic          o_sram_cen,
  output logic          o_sram_wen,
  output logic [AW-1:0] o_sram_addr,
  output logic [DW-1:0] o_sram_din,
  input  logic [DW-1:0] i_sram_dout
);

  state_e        state_q, state_d;
  logic [DW-1:0] dout_q;
  logic          rd_accept;
  logic          rd_oor;
  logic          wr_oor;
  logic          stall;
  tag_t          tag_in;
  tag_t          tag_tap;
  logic          tag_last_vld;
  logic          pipe_empty;

  assign rd_oor = (32'(i_mem_addr) >= DEPTH);
  assign wr_oor = (32'(i_ld_addr) >= DEPTH);

`ifdef MAT_MEM_STALL_INJ_EN
  logic [15:0] lfsr_q;

  // Free-running LFSR; low two bits zero marks a stall cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb(lfsr_q)};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_SERVE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshakes and SRAM port steering
  always_comb begin
    state_d     = state_q;
    o_mem_rrdy  = 1'b0;
    o_ld_wrdy   = 1'b0;
    o_sram_cen  = 1'b0;
    o_sram_wen  = 1'b0;
    o_sram_addr = '0;
    o_sram_din  = '0;
    rd_accept   = 1'b0;
    unique case (state_q)
      S_SERVE: begin
        // rrdy is gated by reset so the handshake stays closed while held
        o_mem_rrdy = i_rst_n & ~i_ld_mode & ~stall;
        rd_accept  = i_mem_rreq & o_mem_rrdy;
        if (rd_accept) begin
          o_sram_cen  = ~rd_oor;
          o_sram_addr = i_mem_addr;
        end
        if (i_ld_mode) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pipe_empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        o_ld_wrdy = i_ld_wreq;
        if (i_ld_wreq && !wr_oor) begin
          o_sram_cen  = 1'b1;
          o_sram_wen  = 1'b1;
          o_sram_addr = i_ld_addr;
          o_sram_din  = i_ld_data;
        end
        if (!i_ld_mode) state_d = S_SERVE;
      end
      default: state_d = S_SERVE;
    endcase
  end

  assign tag_in = {rd_accept, rd_accept & rd_oor};

  mat_mem_tag_pipe #(
    .STAGES (SRAM_LAT + 1)
  ) u_tag_pipe (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .tag_i      (tag_in),
    .tap_o      (tag_tap),
    .last_vld_o (tag_last_vld),
    .empty_o    (pipe_empty)
  );

  // Capture SRAM data when its tag reaches the output; hold otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dout_q <= '0;
    end else if (tag_tap.vld) begin
      dout_q <= tag_tap.oor ? '0 : i_sram_dout;
    end
  end

  assign o_mem_dout     = dout_q;
  assign o_mem_dout_vld = tag_last_vld;
  assign o_ld_busy      = (state_q == S_DRAIN) || (state_q == S_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_mat_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat_mem_resp
// Brief    : Self-checking bench for mat_mem_resp with a behavioural SRAM
//            and a scoreboard of expected read returns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat_mem_resp;

  localparam int AW       = 10;
  localparam int DW       = 256;
  localparam int DEPTH    = 1000;
  localparam int SRAM_LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_rreq = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic          mem_rrdy;
  logic [DW-1:0] mem_dout;
  logic          mem_dout_vld;
  logic          ld_mode = 1'b0;
  logic          ld_wreq = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_wrdy;
  logic          ld_busy;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mat_mem_resp #(
    .AW       (AW),
    .DW       (DW),
    .DEPTH    (DEPTH),
    .SRAM_LAT (SRAM_LAT)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_mem_rreq     (mem_rreq),
    .i_mem_addr     (mem_addr),
    .o_mem_rrdy     (mem_rrdy),
    .o_mem_dout     (mem_dout),
    .o_mem_dout_vld (mem_dout_vld),
    .i_ld_mode      (ld_mode),
    .i_ld_wreq      (ld_wreq),
    .i_ld_addr      (ld_addr),
    .i_ld_data      (ld_data),
    .o_ld_wrdy      (ld_wrdy),
    .o_ld_busy      (ld_busy),
    .o_sram_cen     (sram_cen),
    .o_sram_wen     (sram_wen),
    .o_sram_addr    (sram_addr),
    .o_sram_din     (sram_din),
    .i_sram_dout    (sram_dout)
  );

  // Single-port SRAM, one-cycle read latency
  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic [DW-1:0] sram_q = '0;
  always @(posedge clk) begin
    if (sram_cen) begin
      if (sram_wen) sram[sram_addr] <= sram_din;
      else          sram_q <= sram[sram_addr];
    end
  end
  assign sram_dout = sram_q;

  // Return-path monitor: every vld pulse must match the oldest expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && mem_dout_vld) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_vld: got vld=1 at cycle %0d, expected no response", cyc);
      end else begin
        e = exp_q.pop_front();
        vectors++;
        if (mem_dout !== e.data) begin
          miscompares++;
          $display("FAIL rd_data: got %h expected %h", mem_dout, e.data);
        end
        vectors++;
        if (cyc != e.cyc + SRAM_LAT + 1) begin
          miscompares++;
          $display("FAIL rd_latency: got vld at cycle %0d expected cycle %0d", cyc, e.cyc + SRAM_LAT + 1);
        end
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    mem_rreq = 1'b0;
    ld_wreq  = 1'b0;
  endtask

  // Present a read until accepted; push its expected return
  task automatic do_read(input logic [AW-1:0] a);
    bit done = 1'b0;
    int n = 0;
    exp_t e;
    while (!done && n < 64) begin
      @(negedge clk);
      mem_rreq = 1'b1;
      mem_addr = a;
      #1;
      if (mem_rrdy) begin
        done = 1'b1;
        vectors++;
        if (sram_cen !== (32'(a) < DEPTH) || sram_wen !== 1'b0) begin
          miscompares++;
          $display("FAIL rd_sram_en addr=%h: got cen=%b wen=%b expected cen=%b wen=0", a, sram_cen, sram_wen, (32'(a) < DEPTH));
        end
        e.data = (32'(a) < DEPTH) ? ref_mem[a] : '0;
        e.cyc  = cyc;
        exp_q.push_back(e);
      end
      n++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL rd_accept_timeout addr=%h: got rrdy=0 for 64 cycles, expected accept", a);
    end
  endtask

  // Loader write while in S_LOAD
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit inr;
    inr = (32'(a) < DEPTH);
    @(negedge clk);
    ld_wreq = 1'b1;
    ld_addr = a;
    ld_data = d;
    #1;
    vectors++;
    if (ld_wrdy !== 1'b1 || sram_cen !== inr || sram_wen !== inr) begin
      miscompares++;
      $display("FAIL ld_write addr=%h: got wrdy=%b cen=%b wen=%b expected wrdy=1 cen=%b wen=%b", a, ld_wrdy, sram_cen, sram_wen, inr, inr);
    end
    if (inr) begin
      vectors++;
      if (sram_addr !== a || sram_din !== d) begin
        miscompares++;
        $display("FAIL ld_sram_bus addr=%h: got addr=%h expected addr=%h", a, sram_addr, a);
      end
      ref_mem[a] = d;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    mem_rreq = 1'b1;
    mem_addr = 10'h001;
    #1;
    vectors++;
    if (mem_rrdy !== 1'b0 || mem_dout_vld !== 1'b0 || mem_dout !== '0 || sram_cen !== 1'b0 ||
        sram_wen !== 1'b0 || ld_busy !== 1'b0 || ld_wrdy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rrdy=%b vld=%b cen=%b wen=%b busy=%b wrdy=%b expected all 0",
               mem_rrdy, mem_dout_vld, sram_cen, sram_wen, ld_busy, ld_wrdy);
    end
    @(negedge clk);
    mem_rreq = 1'b0;
    rst_n    = 1'b1;
    #1;
    vectors++;
    if (mem_rrdy !== 1'b1 || ld_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got rrdy=%b busy=%b expected rrdy=1 busy=0", mem_rrdy, ld_busy);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    ld_mode  = 1'b1;
    mem_rreq = 1'b1;
    mem_addr = 10'h002;
    #1;
    vectors++;
    if (mem_rrdy !== 1'b0 || sram_cen !== 1'b0) begin
      miscompares++;
      $display("FAIL ld_mode_rrdy_drop: got rrdy=%b cen=%b expected 0 0", mem_rrdy, sram_cen);
    end
    @(negedge clk);
    mem_rreq = 1'b0;
    #1;
    vectors++;
    if (ld_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_busy: got busy=%b expected 1", ld_busy);
    end
    @(negedge clk);
    for (int i = 0; i < 18; i++) do_write(AW'(i), {8{$urandom()}});
    do_write(10'h012, {16{16'h0101}});
    do_write(10'd999, {8{32'hC0DE_0999}});
    do_write(10'h3FF, {DW{1'b1}});
    @(negedge clk);
    ld_wreq = 1'b0;
    ld_mode = 1'b0;
    do_read(10'h012);
    idle();
  endtask

  task automatic test_streaming();
    int accepted = 0;
    int n = 0;
    logic [AW-1:0] a = '0;
    exp_t e;
    while (accepted < 17 && n < 200) begin
      @(negedge clk);
      mem_rreq = 1'b1;
      mem_addr = a;
      ld_wreq  = 1'b1;
      ld_addr  = 10'h003;
      ld_data  = '1;
      #1;
      vectors++;
      if (ld_wrdy !== 1'b0 || sram_wen !== 1'b0) begin
        miscompares++;
        $display("FAIL serve_wreq_ignored: got wrdy=%b wen=%b expected 0 0", ld_wrdy, sram_wen);
      end
`ifndef MAT_MEM_STALL_INJ_EN
      vectors++;
      if (mem_rrdy !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_rrdy: got rrdy=%b expected 1", mem_rrdy);
      end
`endif
      if (mem_rrdy) begin
        e.data = ref_mem[a];
        e.cyc  = cyc;
        exp_q.push_back(e);
        a++;
        accepted++;
      end
      n++;
    end
    idle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_out_of_range();
    do_read(10'h3FF);
    do_read(10'd1000);
    do_read(10'd999);
    idle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mode_switch();
    logic [DW-1:0] nd;
    nd = {8{32'hFEED_0005}};
    do_read(10'h005);
    @(negedge clk);
    ld_mode  = 1'b1;
    mem_rreq = 1'b1;
    mem_addr = 10'h006;
    ld_wreq  = 1'b1;
    ld_addr  = 10'h005;
    ld_data  = nd;
    #1;
    vectors++;
    if (mem_rrdy !== 1'b0 || sram_cen !== 1'b0 || ld_wrdy !== 1'b0) begin
      miscompares++;
      $display("FAIL switch_cycle: got rrdy=%b cen=%b wrdy=%b expected 0 0 0", mem_rrdy, sram_cen, ld_wrdy);
    end
    @(negedge clk);
    mem_rreq = 1'b0;
    #1;
    vectors++;
    if (ld_busy !== 1'b1 || ld_wrdy !== 1'b0 || sram_cen !== 1'b0 || mem_dout_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_inflight: got busy=%b wrdy=%b cen=%b vld=%b expected 1 0 0 1", ld_busy, ld_wrdy, sram_cen, mem_dout_vld);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (ld_busy !== 1'b1 || ld_wrdy !== 1'b0 || sram_cen !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_exit: got busy=%b wrdy=%b cen=%b expected 1 0 0", ld_busy, ld_wrdy, sram_cen);
    end
    do_write(10'h005, nd);
    vectors++;
    if (ld_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL load_busy: got busy=%b expected 1", ld_busy);
    end
    @(negedge clk);
    ld_wreq = 1'b0;
    ld_mode = 1'b0;
    do_read(10'h005);
    idle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_read(10'h007);
    @(negedge clk);
    mem_rreq = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    #1;
    vectors++;
    if (mem_dout_vld !== 1'b0 || mem_dout !== '0 || mem_rrdy !== 1'b0 || sram_cen !== 1'b0 || ld_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got vld=%b rrdy=%b cen=%b busy=%b dout=%h expected all 0",
               mem_dout_vld, mem_rrdy, sram_cen, ld_busy, mem_dout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (mem_rrdy !== 1'b1 || ld_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_release: got rrdy=%b busy=%b expected 1 0", mem_rrdy, ld_busy);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (mem_dout_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_no_vld: got vld=%b expected 0", mem_dout_vld);
      end
    end
    do_read(10'h007);
    idle();
    repeat (4) @(negedge clk);
  endtask

`ifdef MAT_MEM_STALL_INJ_EN
  task automatic test_stall();
    int stalls = 0;
    exp_t e;
    logic [AW-1:0] a;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a = AW'(i % 18);
      mem_rreq = 1'b1;
      mem_addr = a;
      #1;
      if (!mem_rrdy) begin
        stalls++;
      end else begin
        e.data = ref_mem[a];
        e.cyc  = cyc;
        exp_q.push_back(e);
      end
    end
    idle();
    repeat (4) @(negedge clk);
    vectors++;
    if (stalls < 200 || stalls > 300) begin
      miscompares++;
      $display("FAIL stall_rate: got %0d stalls in 1000 cycles expected 200..300", stalls);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_streaming();
    test_out_of_range();
    test_mode_switch();
    test_reset_mid();
`ifdef MAT_MEM_STALL_INJ_EN
    test_stall();
`endif
    repeat (8) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_responses: got %0d outstanding expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
